// File: rtl/rom_pkg.sv
`default_nettype none
// ==========================================================================
// rom_pkg : shared ROM geometry and burst-reader state encoding | rev 1.0
// ==========================================================================
package rom_pkg;

   localparam int ROM_ADDR_W = 4;
   localparam int ROM_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      PRESENT = 2'd3
   } rom_state_t;

endpackage
`default_nettype wire

// File: rtl/rom_burst_reader.sv
`default_nettype none
// ==========================================================================
// rom_burst_reader : walks a ROM address burst, streams words out | rev 1.0
// ==========================================================================
module rom_burst_reader
   import rom_pkg::*;
#(
   parameter int ADDR_W = ROM_ADDR_W,
   parameter int DATA_W = ROM_DATA_W,
   parameter int LEN_W  = ADDR_W + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  burst_len,
   output logic              rom_enable,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   rom_state_t        state;
   rom_state_t        state_d;
   logic [ADDR_W-1:0] addr;
   logic [LEN_W-1:0]  remaining;
   logic              load;
   logic              handshake;
   logic              zero_req;
   logic              last_word;

   assign last_word = (remaining == LEN_W'(1));

   always_comb begin
      state_d   = state;
      load      = 1'b0;
      handshake = 1'b0;
      zero_req  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (burst_len != '0) begin
                  load    = 1'b1;
                  state_d = ISSUE;
               end else begin
                  zero_req = 1'b1;
               end
            end
         end
         ISSUE:   state_d = CAPTURE;
         CAPTURE: state_d = PRESENT;
         PRESENT: begin
            if (out_ready) begin
               handshake = 1'b1;
               state_d   = last_word ? IDLE : ISSUE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   // The address counter only moves on load or handshake, so it doubles as
   // rom_addr and naturally holds its value outside ISSUE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr      <= '0;
         remaining <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= zero_req || (handshake && last_word);
         if (load) begin
            addr      <= base_addr;
            remaining <= burst_len;
         end
         if (state == CAPTURE) begin
            out_data  <= rom_data;
            out_valid <= 1'b1;
         end
         if (handshake) begin
            out_valid <= 1'b0;
            remaining <= remaining - LEN_W'(1);
            if (!last_word) addr <= addr + ADDR_W'(1);
         end
      end
   end

   assign rom_enable = (state == ISSUE);
   assign rom_addr   = addr;
   assign busy       = (state != IDLE);

endmodule
`default_nettype wire
